pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MSP430 core's fetch stage. Advances the fetch address by the decoded instruction length (1–3 words), supports pipeline stall, absolute jumps, and CALL/RET redirects backed by an internal hardware return-address stack. Drives the instruction-memory address and fetch-enable.

## Interface
- `ADDR_W`, 16, address width in bits (≥4).
- `RESET_VEC`, 16'h0002, first fetch address after reset (bit 0 ignored).
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥2).
- `CLK` in 1: single clock; all state updates on posedge.
- `RST_N` in 1: reset, synchronous, active-low.
- `STALL` in 1: hold all state this cycle.
- `ILEN` in 2: length in words of the instruction at `PC`; 0 treated as 1.
- `JMPE` in 1: absolute jump request.
- `JMP_ADDR` in ADDR_W: target for `JMPE` and `CALL`.
- `CALL` in 1: jump to `JMP_ADDR`, push return address.
- `RET` in 1: pop return address, jump to it.
- `PC` out ADDR_W: current fetch address, always even.
- `PC_ENA` out 1: fetch address valid.
- `RAS_EMPTY` out 1: stack holds 0 entries.
- `RAS_FULL` out 1: stack holds RAS_DEPTH entries.
- `RAS_ERR` out 1: sticky overflow/underflow flag.

## Operation
- Sequential address: `seq = PC + 2*max(ILEN,1)`, modulo 2^ADDR_W (wraps silently).
- Per-cycle priority when `RST_N`=1: STALL > RET > CALL > JMPE > sequential.
- STALL: `PC`, stack, count, flags unchanged; all other requests dropped (not queued).
- RET, stack non-empty: `PC <= top`, count−1.
- RET, stack empty: `PC <= seq`, `RAS_ERR <= 1`.
- CALL: `PC <= {JMP_ADDR[ADDR_W-1:1],1'b0}`, push `seq`. If full: oldest entry overwritten (circular), count stays RAS_DEPTH, `RAS_ERR <= 1`.
- JMPE: `PC <= {JMP_ADDR[ADDR_W-1:1],1'b0}`; stack untouched.
- CALL+RET together: RET wins, CALL ignored. CALL+JMPE: CALL wins.
- `RAS_ERR` clears only on reset.
- `RAS_EMPTY`/`RAS_FULL` are registered and reflect the post-update count.

## Timing
- Reset (`RST_N`=0 at a posedge): `PC`=RESET_VEC with bit 0 cleared, `PC_ENA`=0, count=0, `RAS_EMPTY`=1, `RAS_FULL`=0, `RAS_ERR`=0. Stack contents are don't-care.
- `PC_ENA` rises on the first posedge with `RST_N`=1 and stays 1 until the next reset; STALL does not clear it.
- The first posedge after reset also applies the normal update: `PC` leaves RESET_VEC on that edge unless STALL is high.
- Redirect latency: a request sampled at edge n is visible on `PC` after edge n (one cycle). No combinational input-to-output paths.
- Reset asserted mid-sequence overrides every request in that cycle.

## Structure
- `pc_pkg`: `ilen_t` (2-bit), `pc_sel_e` enum {SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_SEQ}, and a `step_words()` function (0→1).
- Sub-module `ret_stack`: circular LIFO (push, pop, top, count, empty, full) parametrised by `ADDR_W` and `RAS_DEPTH`. Overwrite-on-full lives inside it. `pc_sequencer` holds the PC register, select logic, and the error flag.

## Test plan
- Reset, then `ILEN`=1,2,3 on successive cycles: `PC` = 0002, 0004, 0008, 000E; `PC_ENA` goes 0→1 on the first edge.
- `PC`=0010, `ILEN`=2, `CALL`, `JMP_ADDR`=0x4001: `PC`=0x4000 next cycle. Then `RET`: `PC`=0x0014, `RAS_EMPTY`=1.
- Five nested CALLs with RAS_DEPTH=4: `RAS_FULL`=1 and `RAS_ERR`=1. Four RETs return the 2nd–5th return addresses in reverse order. A fifth RET gives a sequential step and `RAS_EMPTY`=1.
- `RET` on empty stack at `PC`=0x0100, `ILEN`=1: `PC`=0x0102, `RAS_ERR`=1 and stays 1.
- `STALL` held 3 cycles with `JMPE`/`CALL`/`RET` toggling: `PC`, count, and flags frozen; after release, only the then-current request acts.
- ADDR_W=16, `PC`=0xFFFE, `ILEN`=2: `PC`=0x0002. Simultaneous CALL+RET on a non-empty stack: pop only, count−1. Reset mid-stream returns all outputs to reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the fetch-stage program counter
package pc_pkg;

  typedef logic [1:0] ilen_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_SEQ
  } pc_sel_e;

  // A zero length would stall fetch forever, so it counts as one word.
  function automatic logic [1:0] step_words(input ilen_t ilen);
    return (ilen == 2'd0) ? 2'd1 : ilen;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - circular return-address stack that overwrites its oldest entry when full
module ret_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         PUSH,
  input  logic                         POP,
  input  logic [ADDR_W-1:0]            PUSH_DATA,
  output logic [ADDR_W-1:0]            TOP,
  output logic [$clog2(RAS_DEPTH):0]   COUNT,
  output logic                         EMPTY,
  output logic                         FULL
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_top;
  logic [PTR_W-1:0]  sp_nxt;
  logic [PTR_W:0]    cnt_nxt;
  logic              push_go;
  logic              pop_go;

  // sp is the next write slot; when full it also points at the oldest entry
  assign sp_top = sp - PTR_W'(1);
  assign TOP    = mem[sp_top];

  always_comb begin
    sp_nxt  = sp;
    cnt_nxt = COUNT;
    pop_go  = POP && !EMPTY;
    push_go = PUSH && !pop_go;
    if (pop_go) begin
      sp_nxt  = sp - PTR_W'(1);
      cnt_nxt = COUNT - (PTR_W + 1)'(1);
    end else if (push_go) begin
      sp_nxt = sp + PTR_W'(1);
      if (COUNT != DEPTH_C) begin
        cnt_nxt = COUNT + (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sp    <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL  <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      COUNT <= cnt_nxt;
      EMPTY <= (cnt_nxt == '0);
      FULL  <= (cnt_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && push_go) begin
      mem[sp] <= PUSH_DATA;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with stall, jump, and CALL/RET via a return stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(16'h0002),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic [1:0]        ILEN,
  input  logic              JMPE,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  input  logic              CALL,
  input  logic              RET,
  output logic [ADDR_W-1:0] PC,
  output logic              PC_ENA,
  output logic              RAS_EMPTY,
  output logic              RAS_FULL,
  output logic              RAS_ERR
);

  localparam int                CNT_W   = $clog2(RAS_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = RESET_VEC & ~ADDR_W'(1);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_push;
  logic              ras_pop;
  logic              err_nxt;

  assign seq_pc = PC + ADDR_W'({step_words(ilen_t'(ILEN)), 1'b0});
  assign jmp_pc = JMP_ADDR & ~ADDR_W'(1);

  always_comb begin
    sel = SEL_SEQ;
    if (STALL) begin
      sel = SEL_HOLD;
    end else if (RET) begin
      sel = SEL_RET;
    end else if (CALL) begin
      sel = SEL_CALL;
    end else if (JMPE) begin
      sel = SEL_JMP;
    end
  end

  // RET on an empty stack degrades to a sequential step and latches the error
  always_comb begin
    pc_nxt   = PC;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_nxt  = RAS_ERR;
    case (sel)
      SEL_HOLD: pc_nxt = PC;
      SEL_RET: begin
        if (ras_cnt != '0) begin
          pc_nxt  = ras_top;
          ras_pop = 1'b1;
        end else begin
          pc_nxt  = seq_pc;
          err_nxt = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_nxt   = jmp_pc;
        ras_push = 1'b1;
        if (ras_cnt == DEPTH_C) begin
          err_nxt = 1'b1;
        end
      end
      SEL_JMP: pc_nxt = jmp_pc;
      default: pc_nxt = seq_pc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PC      <= RST_PC;
      PC_ENA  <= 1'b0;
      RAS_ERR <= 1'b0;
    end else begin
      PC      <= pc_nxt;
      PC_ENA  <= 1'b1;
      RAS_ERR <= err_nxt;
    end
  end

  ret_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ret_stack (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PUSH     (ras_push),
    .POP      (ras_pop),
    .PUSH_DATA(seq_pc),
    .TOP      (ras_top),
    .COUNT    (ras_cnt),
    .EMPTY    (RAS_EMPTY),
    .FULL     (RAS_FULL)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and random scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0;
  logic [1:0]  ILEN = 2'd1;
  logic        JMPE = 1'b0;
  logic [15:0] JMP_ADDR = '0;
  logic        CALL = 1'b0;
  logic        RET = 1'b0;
  logic [15:0] PC;
  logic        PC_ENA;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_ERR;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] pc;
    logic        ena;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc = 16'h0002;
  logic        m_ena = 1'b0;
  logic        m_err = 1'b0;

  pc_sequencer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .STALL    (STALL),
    .ILEN     (ILEN),
    .JMPE     (JMPE),
    .JMP_ADDR (JMP_ADDR),
    .CALL     (CALL),
    .RET      (RET),
    .PC       (PC),
    .PC_ENA   (PC_ENA),
    .RAS_EMPTY(RAS_EMPTY),
    .RAS_FULL (RAS_FULL),
    .RAS_ERR  (RAS_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst_n, input logic stall, input logic [1:0] ilen,
                     input logic jmpe, input logic [15:0] addr, input logic call,
                     input logic ret);
    exp_t        e;
    logic [15:0] seq;
    @(negedge CLK);
    RST_N = rst_n; STALL = stall; ILEN = ilen; JMPE = jmpe;
    JMP_ADDR = addr; CALL = call; RET = ret;
    seq = m_pc + 16'(((ilen == 2'd0) ? 1 : int'(ilen)) * 2);
    if (!rst_n) begin
      m_pc = 16'h0002; m_ena = 1'b0; m_err = 1'b0; m_stack.delete();
    end else begin
      m_ena = 1'b1;
      if (stall) begin
      end else if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = seq; m_err = 1'b1; end
      end else if (call) begin
        if (m_stack.size() == 4) begin void'(m_stack.pop_front()); m_err = 1'b1; end
        m_stack.push_back(seq);
        m_pc = {addr[15:1], 1'b0};
      end else if (jmpe) begin
        m_pc = {addr[15:1], 1'b0};
      end else begin
        m_pc = seq;
      end
    end
    e.pc = m_pc; e.ena = m_ena; e.err = m_err;
    e.empty = (m_stack.size() == 0); e.full = (m_stack.size() == 4);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_underrun", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("pc", PC, e.pc);
      chk("pc_ena", PC_ENA, e.ena);
      chk("ras_empty", RAS_EMPTY, e.empty);
      chk("ras_full", RAS_FULL, e.full);
      chk("ras_err", RAS_ERR, e.err);
    end
  endtask

  task automatic step(input logic [1:0] ilen);
    cyc(1'b1, 1'b0, ilen, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask
  task automatic do_call(input logic [15:0] addr, input logic [1:0] ilen);
    cyc(1'b1, 1'b0, ilen, 1'b0, addr, 1'b1, 1'b0);
  endtask
  task automatic do_ret(input logic [1:0] ilen);
    cyc(1'b1, 1'b0, ilen, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask
  task automatic do_jmp(input logic [15:0] addr);
    cyc(1'b1, 1'b0, 2'd1, 1'b1, addr, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    cyc(1'b0, 1'b0, 2'd1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("tp_reset_pc", PC, 16'h0002);
    chk("tp_reset_ena", PC_ENA, 1'b0);
    step(2'd1);
    chk("tp_first_ena", PC_ENA, 1'b1);
    step(2'd2);
    step(2'd3);
    chk("tp_seq_pc", PC, 16'h000E);
    step(2'd1);
    chk("tp_pc_0010", PC, 16'h0010);
    do_call(16'h4001, 2'd2);
    chk("tp_call_pc", PC, 16'h4000);
    do_ret(2'd1);
    chk("tp_ret_pc", PC, 16'h0014);
    chk("tp_ret_empty", RAS_EMPTY, 1'b1);

    // five nested calls overflow a four-deep stack
    for (int i = 1; i <= 5; i++) do_call(16'(i) << 12, 2'd1);
    chk("tp_ovf_full", RAS_FULL, 1'b1);
    chk("tp_ovf_err", RAS_ERR, 1'b1);
    do_ret(2'd1);
    chk("tp_ret_5th", PC, 16'h4002);
    do_ret(2'd1);
    do_ret(2'd1);
    do_ret(2'd1);
    chk("tp_ret_2nd", PC, 16'h1002);
    do_ret(2'd1);
    chk("tp_ret_underflow_pc", PC, 16'h1004);
    chk("tp_ret_underflow_empty", RAS_EMPTY, 1'b1);

    do_reset();
    do_jmp(16'h0100);
    do_ret(2'd1);
    chk("tp_empty_ret_pc", PC, 16'h0102);
    chk("tp_empty_ret_err", RAS_ERR, 1'b1);
    step(2'd0);
    chk("tp_ilen0_pc", PC, 16'h0104);
    step(2'd3);
    chk("tp_err_sticky", RAS_ERR, 1'b1);

    // stall freezes everything while requests toggle
    do_call(16'h0201, 2'd1);
    cyc(1'b1, 1'b1, 2'd3, 1'b1, 16'h0AA0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 16'h0BB0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 2'd1, 1'b0, 16'h0CC0, 1'b0, 1'b1);
    chk("tp_stall_pc", PC, 16'h0200);
    chk("tp_stall_ena", PC_ENA, 1'b1);
    do_jmp(16'h0301);
    chk("tp_stall_release", PC, 16'h0300);
    chk("tp_stall_release_cnt", RAS_EMPTY, 1'b0);

    do_jmp(16'hFFFE);
    step(2'd2);
    chk("tp_wrap", PC, 16'h0002);

    do_call(16'h0500, 2'd1);
    cyc(1'b1, 1'b0, 2'd1, 1'b0, 16'h0700, 1'b1, 1'b1);
    chk("tp_call_ret_pc", PC, 16'h0004);
    cyc(1'b1, 1'b0, 2'd2, 1'b1, 16'h0900, 1'b1, 1'b0);
    chk("tp_call_beats_jmp", PC, 16'h0900);

    cyc(1'b0, 1'b0, 2'd3, 1'b1, 16'h1234, 1'b1, 1'b1);
    chk("tp_midreset_pc", PC, 16'h0002);
    chk("tp_midreset_empty", RAS_EMPTY, 1'b1);
    chk("tp_midreset_err", RAS_ERR, 1'b0);

    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
